demux_lane_buf: RTL and testbench

- Reverse of the 4-lane tag-based combiner. Accepts one 12-bit word stream and steers each non-zero word into one of four per-lane FIFOs, selected by tag bits [11:10].
- Each lane drains independently under consumer pop control.
- Sits on the receive side, feeding per-class consumers, and applies backpressure upstream via pause.

---
 rtl/demux_lane_buf.sv | 116 +++++++++++
 tb/tb_demux_lane_buf.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/demux_lane_buf.sv
// demux_lane_buf: steers tagged words into four per-lane FIFOs; define DROP_CNT_EN to add the drop_cnt port
module demux_lane_buf #(
  parameter int DATA_W    = 12,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop0,
  input  logic              pop1,
  input  logic              pop2,
  input  logic              pop3,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              valid_out2,
  output logic              valid_out3,
  output logic              pause
`ifdef DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [4][DEPTH];
  logic [DATA_W-1:0] r_dout [4];
  logic [3:0]        r_vout;
  logic [AW-1:0]     r_wp [4];
  logic [AW-1:0]     r_rp [4];
  logic [CW-1:0]     r_cnt [4];
  logic [CW-1:0]     w_cnt_nxt [4];
  logic [3:0]        w_pop;
  logic [3:0]        w_do_pop;
  logic [3:0]        w_do_push;
  logic              w_acc;
  logic [1:0]        w_lane;
  logic              w_pause_nxt;
`ifdef DROP_CNT_EN
  logic              w_drop;
`endif

  assign data_out0  = r_dout[0];
  assign data_out1  = r_dout[1];
  assign data_out2  = r_dout[2];
  assign data_out3  = r_dout[3];
  assign valid_out0 = r_vout[0];
  assign valid_out1 = r_vout[1];
  assign valid_out2 = r_vout[2];
  assign valid_out3 = r_vout[3];

  // per-lane push/pop decisions; a full lane still accepts when it pops the same cycle
  always_comb begin
    w_acc       = valid_in && (data_in != '0);
    w_lane      = data_in[DATA_W-1 -: 2];
    w_pop       = {pop3, pop2, pop1, pop0};
    w_pause_nxt = 1'b0;
`ifdef DROP_CNT_EN
    w_drop      = 1'b0;
`endif
    for (int k = 0; k < 4; k++) begin
      w_do_pop[k]  = w_pop[k] && (r_cnt[k] != '0);
      w_do_push[k] = w_acc && (w_lane == 2'(k)) && ((r_cnt[k] != CW'(DEPTH)) || w_pop[k]);
`ifdef DROP_CNT_EN
      w_drop       = w_drop | (w_acc && (w_lane == 2'(k)) && (r_cnt[k] == CW'(DEPTH)) && !w_pop[k]);
`endif
      w_cnt_nxt[k] = r_cnt[k] + CW'(w_do_push[k]) - CW'(w_do_pop[k]);
      w_pause_nxt  = w_pause_nxt | (w_cnt_nxt[k] >= CW'(AF_THRESH));
    end
  end

  // FIFO storage is left unreset; only pointers and counts define its contents
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (w_do_push[k]) r_mem[k][r_wp[k]] <= data_in;
  end

  // pointers, counts, registered read data and pause
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < 4; k++) begin
        r_wp[k]   <= '0;
        r_rp[k]   <= '0;
        r_cnt[k]  <= '0;
        r_dout[k] <= '0;
      end
      r_vout <= '0;
      pause  <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= w_cnt_nxt[k];
        if (w_do_push[k]) r_wp[k] <= r_wp[k] + AW'(1);
        if (w_do_pop[k]) begin
          r_rp[k]   <= r_rp[k] + AW'(1);
          r_dout[k] <= r_mem[k][r_rp[k]];
        end
      end
      r_vout <= w_do_pop;
      pause  <= w_pause_nxt;
    end
  end

`ifdef DROP_CNT_EN
  // saturating count of words refused by a full lane
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) drop_cnt <= '0;
    else if (w_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_demux_lane_buf.sv
// tb_demux_lane_buf: queue-model checker plus directed literal checks for demux_lane_buf
module tb_demux_lane_buf;
  logic        clk = 0;
  logic        reset_L = 0;
  logic        valid_in = 0;
  logic [11:0] data_in = '0;
  logic [3:0]  pop = '0;
  logic [11:0] dout [4];
  logic [3:0]  vout;
  logic        pause;
  logic [7:0]  drop_cnt;
  int checks = 0;
  int failures = 0;

  demux_lane_buf dut (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .pop0(pop[0]), .pop1(pop[1]), .pop2(pop[2]), .pop3(pop[3]),
    .data_out0(dout[0]), .data_out1(dout[1]), .data_out2(dout[2]), .data_out3(dout[3]),
    .valid_out0(vout[0]), .valid_out1(vout[1]), .valid_out2(vout[2]), .valid_out3(vout[3]),
    .pause(pause)
`ifdef DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );
`ifndef DROP_CNT_EN
  assign drop_cnt = '0;
`endif

  always #5 clk = ~clk;

  logic [11:0] q [4][$];
  logic [11:0] m_dout [4];
  logic [3:0]  m_vout;
  logic        m_pause;
  int          m_drop;

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      m_dout[k] = '0;
    end
    m_vout = '0;
    m_pause = 0;
    m_drop = 0;
  endtask

  initial model_clear();
  always @(negedge reset_L) model_clear();

  // reference: four queues of at most 4 words, popped then pushed each edge
  always @(posedge clk) begin
    if (reset_L) begin
      logic [3:0] ok;
      logic       push;
      int         l;
      push = 0;
      l = data_in[11:10];
      for (int k = 0; k < 4; k++) ok[k] = pop[k] && q[k].size() > 0;
      if (valid_in && data_in != 0) begin
        if (q[l].size() < 4 || pop[l]) push = 1;
        else if (m_drop < 255) m_drop++;
      end
      for (int k = 0; k < 4; k++) if (ok[k]) m_dout[k] = q[k].pop_front();
      m_vout = ok;
      if (push) q[l].push_back(data_in);
      m_pause = 0;
      for (int k = 0; k < 4; k++) if (q[k].size() >= 3) m_pause = 1;
    end
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("model_dout%0d", k), dout[k], m_dout[k]);
      chk($sformatf("model_vout%0d", k), {11'd0, vout[k]}, {11'd0, m_vout[k]});
    end
    chk("model_pause", {11'd0, pause}, {11'd0, m_pause});
`ifdef DROP_CNT_EN
    chk("model_drop", {4'd0, drop_cnt}, {4'd0, m_drop[7:0]});
`endif
  end

  task automatic drive(input logic v, input logic [11:0] d, input logic [3:0] p);
    valid_in = v;
    data_in = d;
    pop = p;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_dout0", dout[0], 12'h000);
    chk("rst_vout", {8'd0, vout}, 12'h000);
    chk("rst_pause", {11'd0, pause}, 12'h000);
    reset_L = 1;
    for (int i = 0; i < 10; i++) drive(1, 12'h000, 4'h0);
    chk("idle_vout", {8'd0, vout}, 12'h000);
    chk("idle_pause", {11'd0, pause}, 12'h000);
    drive(1, 12'h005, 4'h0);
    drive(1, 12'h406, 4'h0);
    drive(1, 12'h807, 4'h0);
    drive(1, 12'hC08, 4'h0);
    drive(0, 12'h000, 4'hF);
    chk("route0", dout[0], 12'h005);
    chk("route1", dout[1], 12'h406);
    chk("route2", dout[2], 12'h807);
    chk("route3", dout[3], 12'hC08);
    chk("route_vout", {8'd0, vout}, 12'h00F);
    drive(0, 12'h000, 4'h0);
    chk("route_pulse", {8'd0, vout}, 12'h000);
    for (int i = 0; i < 4; i++) drive(1, 12'h401 + 12'(i), 4'h0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 12'h000, 4'b0010);
      chk("order_a", dout[1], 12'h401 + 12'(i));
    end
    for (int i = 0; i < 3; i++) drive(1, 12'h405 + 12'(i), 4'h0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 12'h000, 4'b0010);
      chk("order_wrap", dout[1], 12'h405 + 12'(i));
    end
    drive(0, 12'h000, 4'h0);
    drive(1, 12'h801, 4'h0);
    drive(1, 12'h802, 4'h0);
    chk("pause_lo", {11'd0, pause}, 12'h000);
    drive(1, 12'h803, 4'h0);
    chk("pause_hi", {11'd0, pause}, 12'h001);
    drive(1, 12'h804, 4'h0);
    drive(1, 12'h805, 4'h0);
`ifdef DROP_CNT_EN
    chk("drop1", {4'd0, drop_cnt}, 12'h001);
`endif
    drive(1, 12'h8AA, 4'b0100);
    chk("full_pushpop", dout[2], 12'h801);
`ifdef DROP_CNT_EN
    chk("drop_hold", {4'd0, drop_cnt}, 12'h001);
`endif
    drive(0, 12'h000, 4'b0100);
    chk("drain_a", dout[2], 12'h802);
    drive(0, 12'h000, 4'b0100);
    chk("drain_b", dout[2], 12'h803);
    chk("pause_off", {11'd0, pause}, 12'h000);
    drive(0, 12'h000, 4'b0100);
    chk("drain_c", dout[2], 12'h804);
    drive(0, 12'h000, 4'b0100);
    chk("drain_d", dout[2], 12'h8AA);
    drive(0, 12'h000, 4'b1000);
    chk("empty_pop_v", {11'd0, vout[3]}, 12'h000);
    chk("empty_pop_d", dout[3], 12'hC08);
    drive(1, 12'h0AB, 4'b0001);
    chk("empty_pushpop_v", {11'd0, vout[0]}, 12'h000);
    drive(0, 12'h000, 4'b0001);
    chk("empty_pushpop_d", dout[0], 12'h0AB);
    for (int i = 1; i <= 4; i++) drive(1, 12'(i), 4'h0);
    for (int i = 0; i < 300; i++) drive(1, 12'h0FF, 4'h0);
`ifdef DROP_CNT_EN
    chk("drop_sat", {4'd0, drop_cnt}, 12'h0FF);
`endif
    for (int i = 1; i <= 4; i++) begin
      drive(0, 12'h000, 4'b0001);
      chk("sat_drain", dout[0], 12'(i));
    end
    drive(1, 12'h011, 4'h0);
    drive(1, 12'h012, 4'h0);
    drive(1, 12'h411, 4'h0);
    drive(1, 12'h412, 4'h0);
    drive(0, 12'h000, 4'b0010);
    chk("pre_rst", dout[1], 12'h411);
    pop = 4'h0;
    @(posedge clk);
    #2 reset_L = 0;
    #1;
    chk("async_dout1", dout[1], 12'h000);
    chk("async_pause", {11'd0, pause}, 12'h000);
`ifdef DROP_CNT_EN
    chk("async_drop", {4'd0, drop_cnt}, 12'h000);
`endif
    @(negedge clk);
    reset_L = 1;
    drive(0, 12'h000, 4'b0001);
    chk("post_rst_pop", {11'd0, vout[0]}, 12'h000);
    drive(0, 12'h000, 4'b0010);
    chk("post_rst_pop1", {11'd0, vout[1]}, 12'h000);
    drive(0, 12'h000, 4'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
